// File: rtl/ideal_rotate_springs.sv
// Ideal-shape spring block: fits the best rotation of the ideal shape about the axle,
// then streams one saturated spring/damper force per node and the summed axle reaction.
module ideal_rotate_springs #(
  parameter int NUM_NODES     = 10,
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int FORCE_SIZE    = 8,
  parameter int FRAC_BITS     = 8,
  parameter int K             = 1,
  parameter int B             = 0,
  parameter int FORCE_SHIFT   = 0
) (
  input  logic                                            clk_in,
  input  logic                                            rst_in,
  input  logic                                            input_valid,
  input  logic                                            rotate_en,
  input  logic [1:0][POSITION_SIZE-1:0]                   axle,
  input  logic [1:0][VELOCITY_SIZE-1:0]                   axle_velocity,
  input  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]    nodes,
  input  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]    ideal,
  input  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]    velocities,
  output logic signed [FORCE_SIZE-1:0]                    force_x_out,
  output logic signed [FORCE_SIZE-1:0]                    force_y_out,
  output logic [$clog2(NUM_NODES)-1:0]                    force_node_out,
  output logic                                            force_out_valid,
  output logic signed [FORCE_SIZE-1:0]                    axle_force_x,
  output logic signed [FORCE_SIZE-1:0]                    axle_force_y,
  output logic                                            output_valid,
  output logic                                            busy
);
  localparam int IW    = $clog2(NUM_NODES);
  localparam int SUM_W = 2*POSITION_SIZE + 2 + $clog2(NUM_NODES);
  localparam int RW    = SUM_W + 3;
  localparam int QW    = FRAC_BITS + 2;
  localparam int CW    = FRAC_BITS + 3;
  localparam int WIDE  = POSITION_SIZE + VELOCITY_SIZE + FRAC_BITS + 48;
  localparam int CNT_W = $clog2(SUM_W + FRAC_BITS + 4);
  localparam logic signed [CW-1:0] COS_ONE = CW'(2**FRAC_BITS);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_SQRT, S_DIV_COS, S_DIV_SIN, S_FORCE, S_DONE} state_t;

  function automatic logic signed [FORCE_SIZE-1:0] sat_force(input logic signed [WIDE-1:0] v);
    logic signed [WIDE-1:0] hi, lo;
    hi = '0; hi[FORCE_SIZE-2:0] = '1;
    lo = '1; lo[FORCE_SIZE-2:0] = '0;
    if (v > hi)      return hi[FORCE_SIZE-1:0];
    else if (v < lo) return lo[FORCE_SIZE-1:0];
    else             return v[FORCE_SIZE-1:0];
  endfunction

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [SUM_W-1:0]  dsum_q, dsum_d, csum_q, csum_d;
  logic [RW-1:0]            rem_q, rem_d;
  logic [SUM_W-1:0]         m_q, m_d;
  logic [QW-1:0]            quo_q, quo_d;
  logic signed [CW-1:0]     cos_q, cos_d, sin_q, sin_d;
  logic signed [WIDE-1:0]   sumx_q, sumx_d, sumy_q, sumy_d;
  logic signed [FORCE_SIZE-1:0] fx_q, fx_d, fy_q, fy_d, ax_q, ax_d, ay_q, ay_d;
  logic [IW-1:0]            fnode_q, fnode_d;
  logic                     fvld_q, fvld_d, ovld_q, ovld_d;

  // Fit sums: dot (D) and cross (C) of ideal offset with node-relative position
  logic signed [SUM_W-1:0] ix_s, iy_s, rx_s, ry_s, acc_dot, acc_crs;
  assign ix_s    = SUM_W'($signed(ideal[0][idx_q]));
  assign iy_s    = SUM_W'($signed(ideal[1][idx_q]));
  assign rx_s    = SUM_W'($signed(nodes[0][idx_q])) - SUM_W'($signed(axle[0]));
  assign ry_s    = SUM_W'($signed(nodes[1][idx_q])) - SUM_W'($signed(axle[1]));
  assign acc_dot = ix_s*rx_s + iy_s*ry_s;
  assign acc_crs = ix_s*ry_s - iy_s*rx_s;

  // Restoring square root of D*D + C*C, radicand consumed two bits per cycle from the top
  logic signed [2*SUM_W-1:0] d_ext, c_ext, d_sq, c_sq;
  logic [2*SUM_W-1:0]        sq_sum;
  logic [1:0]                sq_pair;
  int                        sq_sh;
  logic [RW+1:0]             sq_t, sq_trial;
  logic                      sq_ge;
  assign d_ext  = (2*SUM_W)'(dsum_q);
  assign c_ext  = (2*SUM_W)'(csum_q);
  assign d_sq   = d_ext*d_ext;
  assign c_sq   = c_ext*c_ext;
  assign sq_sum = $unsigned(d_sq) + $unsigned(c_sq);
  always_comb begin
    sq_sh = 0;
    if (cnt_q < CNT_W'(SUM_W)) sq_sh = 2*(SUM_W - 1 - int'(cnt_q));
    sq_pair = sq_sum[sq_sh +: 2];
  end
  assign sq_t     = {rem_q, sq_pair};
  assign sq_trial = (RW+2)'({m_q, 2'b01});
  assign sq_ge    = (sq_t >= sq_trial);

  // Divider: remainder starts at |op|>>2, then shifts in op[1], op[0] and FRAC_BITS zeros
  logic [SUM_W-1:0]     abs_d, abs_c, dv_op;
  logic                 dv_bit, dv_ge, dv_neg;
  logic [RW:0]          dv_t, dv_m;
  logic [QW-1:0]        quo_nxt;
  logic signed [CW-1:0] dv_mag, dv_res;
  assign abs_d   = dsum_q[SUM_W-1] ? -dsum_q : dsum_q;
  assign abs_c   = csum_q[SUM_W-1] ? -csum_q : csum_q;
  assign dv_op   = (state_q == S_DIV_SIN) ? abs_c : abs_d;
  assign dv_neg  = (state_q == S_DIV_SIN) ? csum_q[SUM_W-1] : dsum_q[SUM_W-1];
  assign dv_bit  = (cnt_q == '0) ? dv_op[1] : ((cnt_q == CNT_W'(1)) ? dv_op[0] : 1'b0);
  assign dv_t    = {rem_q, dv_bit};
  assign dv_m    = (RW+1)'(m_q);
  assign dv_ge   = (dv_t >= dv_m);
  assign quo_nxt = QW'({quo_q, dv_ge});
  assign dv_mag  = $signed({1'b0, quo_nxt});
  assign dv_res  = dv_neg ? -dv_mag : dv_mag;

  // Per-node force from the rotated ideal position
  logic signed [WIDE-1:0] cw, sw, ixw, iyw, nxw, nyw, axw, ayw, vxw, vyw, avxw, avyw;
  logic signed [WIDE-1:0] kw, bw, rotx, roty, fx_raw, fy_raw;
  assign cw     = WIDE'(cos_q);
  assign sw     = WIDE'(sin_q);
  assign ixw    = WIDE'($signed(ideal[0][idx_q]));
  assign iyw    = WIDE'($signed(ideal[1][idx_q]));
  assign nxw    = WIDE'($signed(nodes[0][idx_q]));
  assign nyw    = WIDE'($signed(nodes[1][idx_q]));
  assign axw    = WIDE'($signed(axle[0]));
  assign ayw    = WIDE'($signed(axle[1]));
  assign vxw    = WIDE'($signed(velocities[0][idx_q]));
  assign vyw    = WIDE'($signed(velocities[1][idx_q]));
  assign avxw   = WIDE'($signed(axle_velocity[0]));
  assign avyw   = WIDE'($signed(axle_velocity[1]));
  assign kw     = WIDE'(K);
  assign bw     = WIDE'(B);
  assign rotx   = (cw*ixw - sw*iyw) >>> FRAC_BITS;
  assign roty   = (sw*ixw + cw*iyw) >>> FRAC_BITS;
  assign fx_raw = (kw*(axw + rotx - nxw) - bw*(vxw - avxw)) >>> FORCE_SHIFT;
  assign fy_raw = (kw*(ayw + roty - nyw) - bw*(vyw - avyw)) >>> FORCE_SHIFT;

  always_comb begin
    state_d = state_q; idx_d = idx_q; cnt_d = cnt_q;
    dsum_d = dsum_q; csum_d = csum_q; rem_d = rem_q; m_d = m_q; quo_d = quo_q;
    cos_d = cos_q; sin_d = sin_q; sumx_d = sumx_q; sumy_d = sumy_q;
    fx_d = fx_q; fy_d = fy_q; fnode_d = fnode_q; ax_d = ax_q; ay_d = ay_q;
    fvld_d = 1'b0; ovld_d = 1'b0;
    case (state_q)
      S_IDLE: if (input_valid) begin
        idx_d = '0; cnt_d = '0; dsum_d = '0; csum_d = '0; sumx_d = '0; sumy_d = '0;
        if (rotate_en) state_d = S_ACCUM;
        else begin
          cos_d = COS_ONE; sin_d = '0; state_d = S_FORCE;
        end
      end
      S_ACCUM: begin
        dsum_d = dsum_q + acc_dot;
        csum_d = csum_q + acc_crs;
        idx_d  = idx_q + 1'b1;
        if (idx_q == IW'(NUM_NODES-1)) begin
          state_d = S_SQRT; cnt_d = '0; rem_d = '0; m_d = '0;
        end
      end
      S_SQRT: begin
        rem_d = sq_ge ? RW'(sq_t - sq_trial) : RW'(sq_t);
        m_d   = SUM_W'({m_q, sq_ge});
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SUM_W-1)) begin
          state_d = S_DIV_COS; cnt_d = '0; rem_d = RW'(abs_d >> 2); quo_d = '0;
        end
      end
      S_DIV_COS, S_DIV_SIN: begin
        rem_d = dv_ge ? RW'(dv_t - dv_m) : RW'(dv_t);
        quo_d = quo_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(QW-1)) begin
          cnt_d = '0; quo_d = '0;
          if (state_q == S_DIV_COS) begin
            cos_d   = (m_q == '0) ? COS_ONE : dv_res;
            rem_d   = RW'(abs_c >> 2);
            state_d = S_DIV_SIN;
          end else begin
            sin_d   = (m_q == '0) ? '0 : dv_res;
            idx_d   = '0;
            state_d = S_FORCE;
          end
        end
      end
      S_FORCE: begin
        fx_d    = sat_force(fx_raw);
        fy_d    = sat_force(fy_raw);
        fnode_d = idx_q;
        fvld_d  = 1'b1;
        sumx_d  = sumx_q + fx_raw;
        sumy_d  = sumy_q + fy_raw;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(NUM_NODES-1)) state_d = S_DONE;
      end
      S_DONE: begin
        ax_d    = sat_force(-sumx_q);
        ay_d    = sat_force(-sumy_q);
        ovld_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE; idx_q <= '0; cnt_q <= '0;
      dsum_q <= '0; csum_q <= '0; rem_q <= '0; m_q <= '0; quo_q <= '0;
      cos_q <= '0; sin_q <= '0; sumx_q <= '0; sumy_q <= '0;
      fx_q <= '0; fy_q <= '0; fnode_q <= '0; ax_q <= '0; ay_q <= '0;
      fvld_q <= 1'b0; ovld_q <= 1'b0;
    end else begin
      state_q <= state_d; idx_q <= idx_d; cnt_q <= cnt_d;
      dsum_q <= dsum_d; csum_q <= csum_d; rem_q <= rem_d; m_q <= m_d; quo_q <= quo_d;
      cos_q <= cos_d; sin_q <= sin_d; sumx_q <= sumx_d; sumy_q <= sumy_d;
      fx_q <= fx_d; fy_q <= fy_d; fnode_q <= fnode_d; ax_q <= ax_d; ay_q <= ay_d;
      fvld_q <= fvld_d; ovld_q <= ovld_d;
    end
  end

  assign force_x_out     = fx_q;
  assign force_y_out     = fy_q;
  assign force_node_out  = fnode_q;
  assign force_out_valid = fvld_q;
  assign axle_force_x    = ax_q;
  assign axle_force_y    = ay_q;
  assign output_valid    = ovld_q;
  assign busy            = (state_q != S_IDLE);
endmodule
